// File: rtl/spi_sub_sync_if.sv
// SPI subordinate bus bundle: chip-side serial pins plus the word-level
// handshake towards the AES core. The slave modport is the subordinate
// itself; the master modport is whatever drives the pins and consumes rx.
interface spi_sub_sync_if #(
    parameter int WIDTH = 128
);
    logic             cs_n;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    logic             frame_err;

    modport slave (
        input  cs_n,
        input  sclk,
        input  mosi,
        input  tx_data,
        input  tx_load,
        output miso,
        output rx_data,
        output rx_valid,
        output busy,
        output frame_err
    );

    modport master (
        output cs_n,
        output sclk,
        output mosi,
        output tx_data,
        output tx_load,
        input  miso,
        input  rx_data,
        input  rx_valid,
        input  busy,
        input  frame_err
    );
endinterface

// File: rtl/spi_sub_sync.sv
// Single-clock SPI subordinate (mode 0, MSB first). cs_n, sclk and mosi are
// oversampled in the clk domain through SYNC_STAGES-deep synchronizers; all
// edge detection and shifting happens on clk, nothing is clocked by sclk.
module spi_sub_sync #(
    parameter int WIDTH       = 128,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst,
    spi_sub_sync_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_sclk_d;
    logic [WIDTH-1:0]       r_tx_buf;
    logic [WIDTH-1:0]       r_tx_sh;
    logic [WIDTH-1:0]       r_rx_sh;
    logic [WIDTH-1:0]       r_rx_data;
    logic [CW-1:0]          r_bit_cnt;
    logic                   r_miso;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_rx_pend;

    logic                   w_cs_s;
    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;

    // Pin synchronizers plus one-cycle delayed copies for edge detection;
    // cs_n idles high and sclk idles low so reset does not fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_cs_d      <= w_cs_s;
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_d & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_d & w_cs_s;
    assign w_sclk_rise = ~r_sclk_d & w_sclk_s;
    assign w_sclk_fall = r_sclk_d & ~w_sclk_s;

    // Transmit buffer: loadable any cycle; a frame only sees it at cs_n fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_buf <= '0;
        end else if (bus.tx_load) begin
            r_tx_buf <= bus.tx_data;
        end
    end

    // Frame FSM: capture tx word at cs_n fall, shift on sclk edges, publish rx word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_rx_data   <= '0;
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_pend   <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_tx_sh   <= r_tx_buf;
                        r_miso    <= r_tx_buf[WIDTH-1];
                        r_bit_cnt <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs_n rising takes priority over a coincident sclk edge;
                    // the bit on that edge is dropped.
                    if (w_cs_rise) begin
                        r_frame_err <= 1'b1;
                        r_miso      <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_sclk_rise) begin
                        r_rx_sh   <= {r_rx_sh[WIDTH-2:0], w_mosi_s};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                        if (r_bit_cnt == CW'(WIDTH - 1)) begin
                            r_rx_pend <= 1'b1;
                            r_miso    <= 1'b0;
                            r_state   <= DONE;
                        end
                    end else if (w_sclk_fall) begin
                        r_tx_sh <= r_tx_sh << 1;
                        r_miso  <= r_tx_sh[WIDTH-2];
                    end
                end
                DONE: begin
                    // rx_data is published on the first DONE cycle so the last
                    // shifted bit has settled in rx_sh; bit_cnt stays at WIDTH.
                    r_miso <= 1'b0;
                    if (r_rx_pend) begin
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                        r_rx_pend  <= 1'b0;
                    end
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_miso  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.miso      = r_miso;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_spi_sub_sync.sv
// Bench for spi_sub_sync: drives SPI frames on the pins, models the expected
// word exchange and output timing from pin-edge latencies, and compares the
// DUT outputs every clk cycle.
module tb_spi_sub_sync;
    localparam int W     = 128;
    localparam int SYNC  = 2;
    localparam int SETUP = 5;
    localparam int HALF  = 5;

    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] data;
    } ev_t;

    logic clk;
    logic rst;

    spi_sub_sync_if #(.WIDTH(W)) bus ();

    spi_sub_sync #(
        .WIDTH       (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned  cyc = 0;
    logic         rst_at_edge = 1'b0;
    logic [7:0]   hist = '1;
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_valid = 0;
    int           n_ferr = 0;
    logic [W-1:0] m_txbuf;
    logic [W-1:0] m_rx;
    int unsigned  quiet_end = 0;
    ev_t          vq[$];
    int unsigned  eq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
        hist        <= {hist[6:0], bus.cs_n};
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        logic ev;
        logic eerr;
        logic eb;
        m_rx = '0;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (rst_at_edge) begin
                    m_rx = '0;
                    vq.delete();
                    eq.delete();
                    quiet_end = cyc + SYNC + 1;
                end
                while (vq.size() > 0 && vq[0].cyc < cyc) void'(vq.pop_front());
                while (eq.size() > 0 && eq[0] < cyc) void'(eq.pop_front());
                ev = 1'b0;
                if (vq.size() > 0 && vq[0].cyc == cyc) begin
                    ev   = 1'b1;
                    m_rx = vq[0].data;
                    void'(vq.pop_front());
                end
                eerr = 1'b0;
                if (eq.size() > 0 && eq[0] == cyc) begin
                    eerr = 1'b1;
                    void'(eq.pop_front());
                end
                eb = (cyc < quiet_end) ? 1'b0 : ~hist[SYNC];
                chk("rx_valid", W'(bus.rx_valid), W'(ev));
                chk("rx_data", bus.rx_data, m_rx);
                chk("frame_err", W'(bus.frame_err), W'(eerr));
                chk("busy", W'(bus.busy), W'(eb));
                if (bus.rx_valid === 1'b1) n_valid++;
                if (bus.frame_err === 1'b1) n_ferr++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.tx_load = 1'b0;
    endtask

    task automatic load_now(input logic [W-1:0] v);
        bus.tx_load = 1'b1;
        bus.tx_data = v;
        m_txbuf     = v;
    endtask

    task automatic load(input logic [W-1:0] v);
        load_now(v);
        tick();
    endtask

    // load_pt: -1 none, -2 together with the cs_n-fall capture, >=0 at that bit.
    // rst_at: bit index at which reset is pulsed instead of the sclk rise (-1 none).
    task automatic frame(input logic [W-1:0] mo, input int nrise, input int load_pt,
                         input logic [W-1:0] load_val, input int rst_at,
                         output logic [W-1:0] mi);
        logic [W-1:0] exp_tx;
        bit           aborted;
        ev_t          e;
        exp_tx   = m_txbuf;
        mi       = '0;
        aborted  = 1'b0;
        bus.cs_n = 1'b0;
        bus.mosi = mo[W-1];
        for (int k = 1; k <= SETUP; k++) begin
            tick();
            if (k == 2 && load_pt == -2) load_now(load_val);
        end
        for (int i = 0; i < nrise && !aborted; i++) begin
            bus.mosi = (i < W) ? mo[W-1-i] : 1'b0;
            if (load_pt == i) load_now(load_val);
            for (int j = 0; j < HALF; j++) tick();
            if (i == rst_at) begin
                rst = 1'b1;
                tick();
                rst      = 1'b0;
                bus.cs_n = 1'b1;
                bus.sclk = 1'b0;
                bus.mosi = 1'b0;
                m_txbuf  = '0;
                @(negedge clk);
                chk("rst_miso", W'(bus.miso), '0);
                chk("rst_rx_data", bus.rx_data, '0);
                chk("rst_rx_valid", W'(bus.rx_valid), '0);
                chk("rst_busy", W'(bus.busy), '0);
                chk("rst_frame_err", W'(bus.frame_err), '0);
                aborted = 1'b1;
            end else begin
                if (i < W) mi[W-1-i] = bus.miso;
                else chk("miso_after_done", W'(bus.miso), '0);
                bus.sclk = 1'b1;
                if (i == W - 1) begin
                    e.cyc  = cyc + SYNC + 2;
                    e.data = mo;
                    vq.push_back(e);
                end
                for (int j = 0; j < HALF; j++) tick();
                bus.sclk = 1'b0;
            end
        end
        if (!aborted) begin
            for (int j = 0; j < HALF; j++) tick();
            bus.cs_n = 1'b1;
            if (nrise < W) eq.push_back(cyc + SYNC + 1);
            else chk("miso_word", mi, exp_tx);
        end
        for (int j = 0; j < 8; j++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] mi;
        int v0;
        int f0;
        rst         = 1'b1;
        bus.cs_n    = 1'b1;
        bus.sclk    = 1'b0;
        bus.mosi    = 1'b0;
        bus.tx_load = 1'b0;
        bus.tx_data = '0;
        m_txbuf     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("init_miso", W'(bus.miso), '0);
        chk("init_rx_data", bus.rx_data, '0);
        chk("init_busy", W'(bus.busy), '0);
        for (int j = 0; j < 5; j++) tick();

        // 1: single frame exchange
        v0 = n_valid;
        load(128'hfa4d);
        frame(128'h00112233445566778899aabbccddeeff, 128, -1, '0, -1, mi);
        chk("t1_master_rx", mi, 128'hfa4d);
        chk("t1_rx_data", bus.rx_data, 128'h00112233445566778899aabbccddeeff);
        chk("t1_valid_cnt", W'(n_valid - v0), W'(1));

        // 2: back-to-back frames, next tx word loaded while busy
        v0 = n_valid;
        f0 = n_ferr;
        load(128'h555555555555555555);
        frame(128'h99999999999999999, 128, 10, 128'hfa4d, -1, mi);
        chk("t2a_master_rx", mi, 128'h555555555555555555);
        chk("t2a_rx_data", bus.rx_data, 128'h99999999999999999);
        frame(128'habde1, 128, -1, '0, -1, mi);
        chk("t2b_master_rx", mi, 128'hfa4d);
        chk("t2b_rx_data", bus.rx_data, 128'habde1);
        chk("t2_valid_cnt", W'(n_valid - v0), W'(2));
        chk("t2_ferr_cnt", W'(n_ferr - f0), W'(0));

        // 3: short frame then a full one
        v0 = n_valid;
        f0 = n_ferr;
        frame(128'hdeadbeef_cafef00d_12345678_9abcdef0, 64, -1, '0, -1, mi);
        chk("t3_rx_hold", bus.rx_data, 128'habde1);
        chk("t3_ferr_cnt", W'(n_ferr - f0), W'(1));
        chk("t3_valid_cnt", W'(n_valid - v0), W'(0));
        frame(128'h0123456789abcdef0123456789abcdef, 128, -1, '0, -1, mi);
        chk("t3_rx_next", bus.rx_data, 128'h0123456789abcdef0123456789abcdef);
        chk("t3_master_rx", mi, 128'hfa4d);

        // 4: reset mid-frame at bit 100, then a fresh frame
        v0 = n_valid;
        frame(128'hffffffff00000000ffffffff00000000, 128, -1, '0, 100, mi);
        frame(128'h80000000000000000000000000000001, 128, -1, '0, -1, mi);
        chk("t4_rx_data", bus.rx_data, 128'h80000000000000000000000000000001);
        chk("t4_master_rx", mi, '0);
        chk("t4_valid_cnt", W'(n_valid - v0), W'(1));

        // 5: tx_load coincident with capture
        load(128'hcafe);
        frame(128'h11111111222222223333333344444444, 128, -2, 128'h1, -1, mi);
        chk("t5a_master_rx", mi, 128'hcafe);
        frame(128'h0f0f, 128, -1, '0, -1, mi);
        chk("t5b_master_rx", mi, 128'h1);
        chk("t5_rx_data", bus.rx_data, 128'h0f0f);

        // 6: 130 sclk pulses in one frame
        v0 = n_valid;
        frame(128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c, 130, -1, '0, -1, mi);
        chk("t6_rx_data", bus.rx_data, 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c);
        chk("t6_valid_cnt", W'(n_valid - v0), W'(1));
        chk("t6_master_rx", mi, 128'h1);

        for (int j = 0; j < 4; j++) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
